// File: rtl/bmem_arbiter.sv
// bmem_arbiter: round-robin burst arbiter of I-side (i_*) and D-side (d_*) caches onto one burst memory port (bmem_*), clk/rst sync active-high
module bmem_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] bmem_address,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [DATA_WIDTH-1:0] bmem_wdata,
  input  logic [DATA_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_resp
);
  localparam int CW = $clog2(BURST_LEN);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] beat_cnt;
  logic last_d, busy, d_req, last_beat;
  assign busy = state == BUSY_I || state == BUSY_D;
  assign d_req = d_read | d_write;
  assign last_beat = busy && bmem_resp && beat_cnt == CW'(BURST_LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      last_d <= 1'b1;
    end else begin
      state <= state_n;
      if (busy && bmem_resp) beat_cnt <= beat_cnt + 1'b1;
      if (last_beat) last_d <= state == BUSY_D;
    end
  end
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = i_read && (!d_req || last_d) ? BUSY_I : d_req ? BUSY_D : IDLE;
    else if (busy) state_n = last_beat ? GAP : state;
  end
  assign bmem_address = state == BUSY_I ? i_addr : state == BUSY_D ? d_addr : '0;
  assign bmem_read = (state == BUSY_I && i_read) || (state == BUSY_D && d_read);
  assign bmem_write = state == BUSY_D && d_write;
  assign bmem_wdata = state == BUSY_D ? d_wdata : '0;
  assign i_resp = bmem_resp && state == BUSY_I;
  assign d_resp = bmem_resp && state == BUSY_D;
  assign i_rdata = bmem_rdata;
  assign d_rdata = bmem_rdata;
  a_i_hold: assert property (@(posedge clk) disable iff (rst) state == BUSY_I |-> i_read);
  a_d_hold: assert property (@(posedge clk) disable iff (rst) state == BUSY_D |-> d_req);
  a_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: directed self-checking bench for bmem_arbiter
module tb_bmem_arbiter;
  localparam logic [31:0] IA = 32'h6000_0400, WA = 32'h6000_0800, DA = 32'h6000_1000;
  logic clk = 0, rst = 1;
  logic [31:0] i_addr = '0, d_addr = '0, bmem_address;
  logic i_read = 0, d_read = 0, d_write = 0, i_resp, d_resp, bmem_read, bmem_write, bmem_resp = 0;
  logic [63:0] i_rdata, d_rdata, d_wdata = '0, bmem_wdata, bmem_rdata = '0;
  int n_cmp = 0, n_bad = 0;
  bmem_arbiter dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_resp(d_resp), .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic burst(input bit d, input bit wr);
    for (int k = 0; k < 16; k++) begin
      bmem_resp = 1;
      bmem_rdata = 64'h5A00 + 64'(k);
      if (wr) d_wdata = 64'(k);
      #1;
      check("resp", d ? d_resp : i_resp, 1);
      check("other_resp", d ? i_resp : d_resp, 0);
      check("read_held", bmem_read, !(d && wr));
      check("write_held", bmem_write, d && wr);
      if (wr) check("wdata", bmem_wdata, 64'(k));
      else check("rdata", d ? d_rdata : i_rdata, 64'h5A00 + 64'(k));
      tick();
    end
    bmem_resp = 0;
    #1;
    check("gap_read", bmem_read, 0);
    check("gap_write", bmem_write, 0);
    check("gap_addr", bmem_address, 0);
    check("gap_wdata", bmem_wdata, 0);
    check("gap_cnt", dut.beat_cnt, 0);
  endtask
  initial begin
    tick();
    tick();
    check("rst_read", bmem_read, 0);
    check("rst_write", bmem_write, 0);
    check("rst_addr", bmem_address, 0);
    check("rst_wdata", bmem_wdata, 0);
    check("rst_iresp", i_resp, 0);
    check("rst_dresp", d_resp, 0);
    rst = 0;
    i_addr = IA;
    i_read = 1;
    #1;
    check("t1_no_comb", bmem_read, 0);
    tick();
    check("t1_read", bmem_read, 1);
    check("t1_addr", bmem_address, IA);
    check("t1_write", bmem_write, 0);
    burst(0, 0);
    i_read = 0;
    tick();
    check("t1_idle", bmem_read, 0);
    d_addr = WA;
    d_write = 1;
    tick();
    check("t2_write", bmem_write, 1);
    check("t2_addr", bmem_address, WA);
    burst(1, 1);
    d_write = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    i_read = 1;
    d_read = 1;
    d_addr = DA;
    tick();
    check("t3_first_i", bmem_address, IA);
    burst(0, 0);
    i_read = 0;
    tick();
    check("t3_idle_addr", bmem_address, 0);
    check("t3_idle_read", bmem_read, 0);
    tick();
    check("t3_then_d", bmem_address, DA);
    check("t3_d_read", bmem_read, 1);
    burst(1, 0);
    d_read = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    i_read = 1;
    d_read = 1;
    for (int b = 0; b < 4; b++) begin
      tick();
      check("t4_order", bmem_address, b % 2 ? DA : IA);
      burst(b % 2 == 1, 0);
      tick();
    end
    i_read = 0;
    d_read = 0;
    tick();
    d_read = 1;
    tick();
    check("t5_d_grant", bmem_address, DA);
    for (int k = 0; k < 7; k++) begin
      bmem_resp = 1;
      #1;
      check("t5_dresp", d_resp, 1);
      tick();
    end
    bmem_resp = 0;
    i_read = 1;
    rst = 1;
    tick();
    check("t5_rst_read", bmem_read, 0);
    check("t5_rst_addr", bmem_address, 0);
    check("t5_rst_cnt", dut.beat_cnt, 0);
    rst = 0;
    tick();
    check("t5_i_first", bmem_address, IA);
    burst(0, 0);
    i_read = 0;
    d_read = 0;
    tick();
    bmem_resp = 1;
    #1;
    check("t6_idle_iresp", i_resp, 0);
    check("t6_idle_dresp", d_resp, 0);
    tick();
    check("t6_idle_cnt", dut.beat_cnt, 0);
    bmem_resp = 0;
    i_read = 1;
    tick();
    burst(0, 0);
    bmem_resp = 1;
    i_read = 0;
    #1;
    check("t6_gap_iresp", i_resp, 0);
    check("t6_gap_dresp", d_resp, 0);
    tick();
    check("t6_gap_cnt", dut.beat_cnt, 0);
    bmem_resp = 0;
    i_read = 1;
    tick();
    check("t6_regrant", bmem_read, 1);
    burst(0, 0);
    i_read = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
